// File: rtl/vx_ibuffer_pkg.sv
// Shared definitions for the per-warp instruction buffer: default geometry,
// warp-index mapping helpers and the packed entry presented to issue.
package vx_ibuffer_pkg;

  localparam int IBUF_NUM_WARPS = 8;
  localparam int IBUF_ISSUE_CNT = 2;
  localparam int IBUF_DEPTH     = 2;
  localparam int IBUF_DATAW     = 128;

  localparam int WPI  = IBUF_NUM_WARPS / IBUF_ISSUE_CNT;
  localparam int WISW = (WPI > 1) ? $clog2(WPI) : 1;
  localparam int CNTW = $clog2(IBUF_DEPTH + 1);

  // Entry as seen by an issue channel: slot index within the slice plus payload.
  typedef struct packed {
    logic [WISW-1:0]       wis;
    logic [IBUF_DATAW-1:0] data;
  } ibuf_entry_t;

  // Warps are interleaved across channels: low bits pick the channel.
  function automatic int wid_to_isw(input int wid, input int issue_cnt);
    return wid % issue_cnt;
  endfunction

  function automatic int wid_to_wis(input int wid, input int issue_cnt);
    return wid / issue_cnt;
  endfunction

  function automatic int wis_isw_to_wid(input int wis, input int isw, input int issue_cnt);
    return wis * issue_cnt + isw;
  endfunction

endpackage

// File: rtl/vx_ibuf_warp_fifo.sv
// Per-warp circular FIFO. Head is read from registered pointers so an entry
// written in one cycle is presented the next. Flush drops everything at once.
module vx_ibuf_warp_fifo #(
  parameter int DATAW = 128,
  parameter int DEPTH = 2,
  localparam int PTRW = $clog2(DEPTH),
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNTW-1:0]  count,
  output logic [DATAW-1:0] head
);

  logic [DATAW-1:0] ram [DEPTH];
  logic [PTRW-1:0]  rd_ptr_reg;
  logic [PTRW-1:0]  wr_ptr_reg;
  logic [CNTW-1:0]  count_reg;
  logic             push_ok;
  logic             pop_ok;

  // A flushing warp neither accepts nor releases entries this cycle.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // Payload storage; never reset, contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push_ok) ram[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= wr_ptr_reg;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTRW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTRW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNTW'(1);
        2'b01:   count_reg <= count_reg - CNTW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign full  = (count_reg == CNTW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = ram[rd_ptr_reg];

endmodule

// File: rtl/vx_ibuffer_wq.sv
// Instruction buffer with one FIFO per warp. Each issue channel arbitrates
// round-robin among its own warps, so a stalled warp never blocks its peers.
module vx_ibuffer_wq
  import vx_ibuffer_pkg::*;
#(
  parameter int NUM_WARPS = 8,
  parameter int ISSUE_CNT = 2,
  parameter int DEPTH     = 2,
  parameter int DATAW     = 128,
  localparam int L_WPI  = NUM_WARPS / ISSUE_CNT,
  localparam int L_WIDW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int L_WISW = (L_WPI > 1) ? $clog2(L_WPI) : 1,
  localparam int L_CNTW = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [L_WIDW-1:0]             in_wid,
  input  logic [DATAW-1:0]              in_data,
  input  logic [NUM_WARPS-1:0]          flush,
  output logic [ISSUE_CNT-1:0]          out_valid,
  input  logic [ISSUE_CNT-1:0]          out_ready,
  output logic [ISSUE_CNT*L_WISW-1:0]   out_wis,
  output logic [ISSUE_CNT*DATAW-1:0]    out_data,
  output logic [ISSUE_CNT-1:0]          pop,
  output logic [NUM_WARPS*L_CNTW-1:0]   occupancy
);

  logic [NUM_WARPS-1:0] push_w;
  logic [NUM_WARPS-1:0] pop_w;
  logic [NUM_WARPS-1:0] full_w;
  logic [NUM_WARPS-1:0] empty_w;
  logic [DATAW-1:0]     head_w  [NUM_WARPS];
  logic [L_CNTW-1:0]    count_w [NUM_WARPS];

  // Ready depends only on the target warp's registered fullness and its flush,
  // never on a same-cycle pop.
  always_comb begin
    in_ready = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (in_wid == L_WIDW'(w)) in_ready = !full_w[w] && !flush[w];
    end
  end

  genvar gi, gw;

  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      assign push_w[gi] = in_valid && in_ready && (in_wid == L_WIDW'(gi));
      assign occupancy[gi*L_CNTW +: L_CNTW] = count_w[gi];

      vx_ibuf_warp_fifo #(
        .DATAW (DATAW),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_w[gi]),
        .push_data (in_data),
        .pop       (pop_w[gi]),
        .flush     (flush[gi]),
        .full      (full_w[gi]),
        .empty     (empty_w[gi]),
        .count     (count_w[gi]),
        .head      (head_w[gi])
      );
    end

    for (gi = 0; gi < ISSUE_CNT; gi++) begin : g_chan
      logic [L_WPI-1:0]  req;
      logic [DATAW-1:0]  heads [L_WPI];
      logic [L_WISW-1:0] rr_ptr_reg;
      logic [L_WISW-1:0] grant;
      logic              found;
      int                idx;

      for (gw = 0; gw < L_WPI; gw++) begin : g_slot
        localparam int W = wis_isw_to_wid(gw, gi, ISSUE_CNT);
        assign req[gw]   = !empty_w[W] && !flush[W];
        assign heads[gw] = head_w[W];
        assign pop_w[W]  = pop[gi] && (grant == L_WISW'(gw));
      end

      // First requesting slot at or after rr_ptr, wrapping within the slice.
      always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int i = 0; i < L_WPI; i++) begin
          idx = int'(rr_ptr_reg) + i;
          if (idx >= L_WPI) idx = idx - L_WPI;
          if (!found && req[idx]) begin
            found = 1'b1;
            grant = L_WISW'(idx);
          end
        end
      end

      assign out_valid[gi]                    = found;
      assign pop[gi]                          = found && out_ready[gi];
      assign out_wis[gi*L_WISW +: L_WISW]     = grant;
      assign out_data[gi*DATAW +: DATAW]      = heads[grant];

      // Advance past the served slot only when something actually leaves.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rr_ptr_reg <= '0;
        end else if (pop[gi]) begin
          rr_ptr_reg <= (grant == L_WISW'(L_WPI - 1)) ? '0 : grant + L_WISW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_vx_ibuffer_wq.sv
// Scenario bench for vx_ibuffer_wq with a per-warp scoreboard of payloads.
module tb_vx_ibuffer_wq;

  localparam int NUM_WARPS = 8;
  localparam int ISSUE_CNT = 2;
  localparam int DEPTH     = 2;
  localparam int DATAW     = 128;
  localparam int WIDW      = 3;
  localparam int WISW      = 2;
  localparam int CNTW      = 2;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [WIDW-1:0]             in_wid = '0;
  logic [DATAW-1:0]            in_data = '0;
  logic [NUM_WARPS-1:0]        flush = '0;
  logic [ISSUE_CNT-1:0]        out_valid;
  logic [ISSUE_CNT-1:0]        out_ready = '0;
  logic [ISSUE_CNT*WISW-1:0]   out_wis;
  logic [ISSUE_CNT*DATAW-1:0]  out_data;
  logic [ISSUE_CNT-1:0]        pop;
  logic [NUM_WARPS*CNTW-1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               wid;
    logic [DATAW-1:0] data;
  } sb_t;
  sb_t sb[$];

  vx_ibuffer_wq #(
    .NUM_WARPS (NUM_WARPS),
    .ISSUE_CNT (ISSUE_CNT),
    .DEPTH     (DEPTH),
    .DATAW     (DATAW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wid    (in_wid),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wis   (out_wis),
    .out_data  (out_data),
    .pop       (pop),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [CNTW-1:0] occ(input int w);
    return occupancy[w*CNTW +: CNTW];
  endfunction

  function automatic logic [WISW-1:0] wis_of(input int c);
    return out_wis[c*WISW +: WISW];
  endfunction

  function automatic logic [DATAW-1:0] data_of(input int c);
    return out_data[c*DATAW +: DATAW];
  endfunction

  // Scoreboard: accepted pushes are queued per warp; each pop must return
  // the oldest outstanding payload of the warp it names; flush drops a warp.
  always @(negedge clk) begin
    int  wid;
    bit  hit;
    if (reset) begin
      sb.delete();
    end else begin
      for (int c = 0; c < ISSUE_CNT; c++) begin
        if (pop[c]) begin
          wid = int'(wis_of(c)) * ISSUE_CNT + c;
          hit = 1'b0;
          $display("pop ch %0d wid %0d data %h", c, wid, data_of(c));
          checks++;
          if (!out_valid[c]) begin
            errors++;
            $display("FAIL pop_without_valid ch %0d observed out_valid 0 expected 1", c);
          end
          for (int k = 0; k < sb.size(); k++) begin
            if (!hit && sb[k].wid == wid) begin
              hit = 1'b1;
              checks++;
              if (data_of(c) !== sb[k].data) begin
                errors++;
                $display("FAIL sb_data wid %0d observed %h expected %h", wid, data_of(c), sb[k].data);
              end
              sb.delete(k);
            end
          end
          if (!hit) begin
            errors++;
            $display("FAIL sb_unexpected_pop ch %0d wid %0d observed %h expected none", c, wid, data_of(c));
          end
        end
      end
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (flush[w]) begin
          for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].wid == w) sb.delete(k);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back('{int'(in_wid), in_data});
    end
  end

  task automatic push_one(input int wid, input logic [DATAW-1:0] data, output bit acc);
    in_valid = 1'b1;
    in_wid   = WIDW'(wid);
    in_data  = data;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = '1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (occupancy == '0 && out_valid == '0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout observed occupancy %h expected 0", occupancy);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_sb_empty observed %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
    out_ready = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== '0 || pop !== '0) begin
      errors++;
      $display("FAIL reset_outputs observed valid %b pop %b expected 0 0", out_valid, pop);
    end
    checks++;
    if (occupancy !== '0) begin
      errors++;
      $display("FAIL reset_occupancy observed %h expected 0", occupancy);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready observed %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_latency();
    bit acc;
    out_ready = '1;
    push_one(3, 128'hA5, acc);
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL lat_accept observed %b expected 1", acc);
    end
    @(negedge clk);
    checks++;
    if (out_valid[1] !== 1'b1 || pop[1] !== 1'b1 || wis_of(1) !== 2'd1) begin
      errors++;
      $display("FAIL lat_present observed valid %b pop %b wis %0d expected 1 1 1", out_valid[1], pop[1], wis_of(1));
    end
    checks++;
    if (data_of(1) !== 128'hA5) begin
      errors++;
      $display("FAIL lat_data observed %h expected a5", data_of(1));
    end
    checks++;
    if (occ(3) !== 2'd1) begin
      errors++;
      $display("FAIL lat_occ1 observed %0d expected 1", occ(3));
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (occ(3) !== 2'd0 || out_valid !== '0) begin
      errors++;
      $display("FAIL lat_occ0 observed occ %0d valid %b expected 0 0", occ(3), out_valid);
    end
    @(posedge clk);
    #1;
    out_ready = '0;
  endtask

  task automatic test_full_hol();
    bit acc;
    bit exp_acc [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int wids    [4] = '{0, 0, 0, 2};
    out_ready = '0;
    for (int i = 0; i < 4; i++) begin
      push_one(wids[i], DATAW'(32'h100 + i), acc);
      checks++;
      if (acc !== exp_acc[i]) begin
        errors++;
        $display("FAIL full_accept push %0d wid %0d observed %b expected %b", i, wids[i], acc, exp_acc[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (occ(0) !== 2'd2 || occ(2) !== 2'd1) begin
      errors++;
      $display("FAIL full_occ observed %0d %0d expected 2 1", occ(0), occ(2));
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_round_robin();
    bit acc;
    int exp_wis [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 4; i++) push_one(2 * i, DATAW'(32'h10 + i), acc);
    out_ready[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        in_valid = 1'b1;
        in_wid   = 3'd0;
        in_data  = DATAW'(32'h14);
      end
      @(negedge clk);
      checks++;
      if (pop[0] !== 1'b1 || wis_of(0) !== WISW'(exp_wis[i])) begin
        errors++;
        $display("FAIL rr_order step %0d observed pop %b wis %0d expected 1 %0d", i, pop[0], wis_of(0), exp_wis[i]);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL rr_empty observed %b expected 0", out_valid[0]);
    end
    @(posedge clk);
    #1;
    out_ready = '0;
  endtask

  task automatic test_stall();
    bit acc;
    do_reset();
    out_ready = '0;
    push_one(2, 128'h22, acc);
    push_one(4, 128'h44, acc);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_valid = 1'b1;
        in_wid   = 3'd6;
        in_data  = 128'h66;
      end
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b1 || wis_of(0) !== 2'd1 || data_of(0) !== 128'h22) begin
        errors++;
        $display("FAIL stall_hold cycle %0d observed valid %b wis %0d data %h expected 1 1 22", i, out_valid[0], wis_of(0), data_of(0));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (pop[0] !== 1'b1 || wis_of(0) !== 2'd1) begin
      errors++;
      $display("FAIL stall_release observed pop %b wis %0d expected 1 1", pop[0], wis_of(0));
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_flush();
    bit acc;
    do_reset();
    out_ready = '0;
    push_one(5, 128'h51, acc);
    push_one(5, 128'h52, acc);
    push_one(4, 128'h40, acc);
    flush        = 8'b0010_0000;
    in_valid     = 1'b1;
    in_wid       = 3'd5;
    in_data      = 128'h53;
    out_ready    = 2'b10;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready observed %b expected 0", in_ready);
    end
    checks++;
    if (pop[1] !== 1'b0 || out_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_pop observed pop %b valid %b expected 0 0", pop[1], out_valid[1]);
    end
    @(posedge clk);
    #1;
    flush     = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    @(negedge clk);
    checks++;
    if (occ(5) !== 2'd0 || occ(4) !== 2'd1) begin
      errors++;
      $display("FAIL flush_occ observed w5 %0d w4 %0d expected 0 1", occ(5), occ(4));
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_async_reset();
    bit acc;
    int wids [6] = '{0, 0, 1, 1, 2, 3};
    out_ready = '0;
    for (int i = 0; i < 6; i++) push_one(wids[i], DATAW'(32'h200 + i), acc);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== '0 || pop !== '0 || occupancy !== '0) begin
      errors++;
      $display("FAIL async_reset observed valid %b pop %b occ %h expected 0 0 0", out_valid, pop, occupancy);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_in_ready observed %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = '1;
    push_one(7, 128'h77, acc);
    @(negedge clk);
    checks++;
    if (out_valid[1] !== 1'b1 || pop[1] !== 1'b1 || wis_of(1) !== 2'd3 || data_of(1) !== 128'h77) begin
      errors++;
      $display("FAIL async_first_push observed valid %b pop %b wis %0d data %h expected 1 1 3 77", out_valid[1], pop[1], wis_of(1), data_of(1));
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_latency();
    test_full_hol();
    test_round_robin();
    test_stall();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
